ram_ctrl: RTL and testbench

Request-side controller for the 4-entry × 72-bit single-port `ram` block. It accepts read/write commands on a valid/ready interface and drives the RAM port (`enb`/`wr`/`addr`/`data`). It captures the RAM's registered read data and returns it in order on a valid/ready response interface with a credit-limited response FIFO. After every reset it zero-fills the whole RAM before accepting traffic.

---
 rtl/ram_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_ram_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_ctrl.sv
// Request-side controller for a single-port RAM: zero-fills the RAM after reset,
// then forwards read/write commands and returns read data in order through a response FIFO.

// Response FIFO: registered storage, no bypass.
// Latency: pushed data is visible the cycle after the push.
// Backpressure: none internally; the producer guarantees space (credits), overflow is only asserted.
module ram_ctrl_fifo #(
  parameter int W     = 72,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         vld,
  output logic [W-1:0] dat
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic             empty;
  logic             full;
  logic             pop_ok;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                  (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign pop_ok = pop && !empty;
  assign vld    = !empty;
  assign dat    = mem_q[rd_ptr_q[IDX_W-1:0]];

  // A push while full is only legal together with a pop: it reuses the slot being freed.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[IDX_W-1:0]] = push_dat;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  overflow_a: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop_ok));

endmodule

// RAM request controller: INIT zero-fill, then in-order command issue with credit-gated reads.
// Latency: command on RAM port the cycle after accept; read data on rsp 2 cycles after accept.
// Backpressure: req_ready drops when in-flight reads plus queued responses reach RSP_DEPTH.
module ram_ctrl #(
  parameter int ADDR_W    = 2,
  parameter int DATA_W    = 72,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              init_done,
  output logic              ram_enb,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam int CRD_W = $clog2(RSP_DEPTH) + 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  init_cnt_q, init_cnt_d;
  logic [CRD_W-1:0]  credits_q, credits_d;
  logic [1:0]        tag_q, tag_d;
  logic              ram_enb_q, ram_enb_d;
  logic              ram_wr_q, ram_wr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

  logic req_fire;
  logic rd_fire;
  logic rsp_fire;

  assign init_done = (state_q == ST_RUN);
  // Writes share the read gate so commands always leave in arrival order.
  assign req_ready = (state_q == ST_RUN) && (credits_q < CRD_W'(RSP_DEPTH));
  assign req_fire  = req_valid && req_ready;
  assign rd_fire   = req_fire && !req_wr;
  assign rsp_fire  = rsp_valid && rsp_ready;

  assign ram_enb   = ram_enb_q;
  assign ram_wr    = ram_wr_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    ram_enb_d   = 1'b0;
    ram_wr_d    = ram_wr_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == CNT_W'(DEPTH)) begin
          state_d = ST_RUN;
        end else begin
          ram_enb_d   = 1'b1;
          ram_wr_d    = 1'b1;
          ram_addr_d  = init_cnt_q[ADDR_W-1:0];
          ram_wdata_d = '0;
          init_cnt_d  = init_cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (req_fire) begin
          ram_enb_d   = 1'b1;
          ram_wr_d    = req_wr;
          ram_addr_d  = req_addr;
          ram_wdata_d = req_data;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Tag bit 1 lines up with the RAM's registered read data.
  always_comb begin
    tag_d     = {tag_q[0], rd_fire};
    credits_d = credits_q + CRD_W'(rd_fire) - CRD_W'(rsp_fire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      credits_q   <= '0;
      tag_q       <= '0;
      ram_enb_q   <= 1'b0;
      ram_wr_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      credits_q   <= credits_d;
      tag_q       <= tag_d;
      ram_enb_q   <= ram_enb_d;
      ram_wr_q    <= ram_wr_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  ram_ctrl_fifo #(
    .W     (DATA_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (tag_q[1]),
    .push_dat (ram_rdata),
    .pop      (rsp_ready),
    .vld      (rsp_valid),
    .dat      (rsp_data)
  );

  credit_bound_a: assert property (@(posedge clk) disable iff (!rst_n) credits_q <= CRD_W'(RSP_DEPTH));

endmodule

// File: tb/tb_ram_ctrl.sv
// Scoreboard bench for ram_ctrl: behavioural RAM, expected-response queue, randomized traffic.
module tb_ram_ctrl;
  localparam int AW = 2;
  localparam int DW = 72;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          init_done;
  logic          ram_enb;
  logic          ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  ram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RSP_DEPTH(RD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .init_done (init_done),
    .ram_enb   (ram_enb),
    .ram_wr    (ram_wr),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read data; starts with junk so the zero-fill matters.
  logic [DW-1:0] ram_mem [4] = '{72'hDE_ADBE_EF01_2345_6789, 72'h55_AAAA_5555_AAAA_5555,
                                 72'hC3_0FF0_1234_ABCD_EF00, 72'h7E_1111_2222_3333_4444};
  always @(posedge clk) begin
    if (ram_enb) begin
      if (ram_wr) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  typedef struct {
    logic [DW-1:0] d;
    int            e;
  } exp_t;

  exp_t          q[$];
  exp_t          tmp;
  logic [DW-1:0] mmem [4];
  int            cyc = 0;
  int            nvec = 0;
  int            nerr = 0;
  logic          prev_vld = 1'b0;
  logic          prev_rdy = 1'b0;
  logic [DW-1:0] prev_dat = '0;
  logic          rand_rdy = 1'b0;
  logic          rdy_fixed = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rnd72();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    rsp_ready = rand_rdy ? 1'($urandom() % 2) : rdy_fixed;
  end

  // Monitor: reference is a plain memory array plus an ordered list of expected read results,
  // each tagged with the edge it was accepted on (response due two edges later).
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_rsp_valid", DW'(rsp_valid), '0);
      q.delete();
      for (int i = 0; i < 4; i++) mmem[i] = '0;
      prev_vld = 1'b0;
      prev_rdy = 1'b0;
    end else begin
      if (q.size() == 0) chk("rsp_spurious", DW'(rsp_valid), '0);
      else if (q[0].e + 2 <= cyc) chk("rsp_due", DW'(rsp_valid), DW'(1));
      if (rsp_valid && !prev_vld && q.size() > 0) chk("rsp_latency", DW'(cyc), DW'(q[0].e + 2));
      if (prev_vld && !prev_rdy && rsp_valid) chk("rsp_hold", rsp_data, prev_dat);
      if (rsp_valid && rsp_ready && q.size() > 0) begin
        chk("rsp_data", rsp_data, q[0].d);
        void'(q.pop_front());
      end
      prev_vld = rsp_valid;
      prev_rdy = rsp_ready;
      prev_dat = rsp_data;
      if (req_valid && req_ready) begin
        if (req_wr) begin
          mmem[req_addr] = req_data;
        end else begin
          tmp.d = mmem[req_addr];
          tmp.e = cyc + 1;
          q.push_back(tmp);
        end
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, DW'(req_ready), '0);
    chk({tag, "_rsp_valid"}, DW'(rsp_valid), '0);
    chk({tag, "_rsp_data"},  rsp_data, '0);
    chk({tag, "_init_done"}, DW'(init_done), '0);
    chk({tag, "_ram_enb"},   DW'(ram_enb), '0);
    chk({tag, "_ram_wr"},    DW'(ram_wr), '0);
    chk({tag, "_ram_addr"},  DW'(ram_addr), '0);
    chk({tag, "_ram_wdata"}, ram_wdata, '0);
  endtask

  // Called at the reset-release instant (just after an edge).
  task automatic chk_init();
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk("init_enb", DW'(ram_enb), DW'(1));
      chk("init_wr", DW'(ram_wr), DW'(1));
      chk("init_addr", DW'(ram_addr), DW'(k - 1));
      chk("init_wdata", ram_wdata, '0);
      chk("init_done_low", DW'(init_done), '0);
      chk("init_ready_low", DW'(req_ready), '0);
    end
    @(posedge clk); #1;
    chk("init_done_high", DW'(init_done), DW'(1));
    chk("init_ready_high", DW'(req_ready), DW'(1));
    chk("init_enb_idle", DW'(ram_enb), '0);
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int stalls);
    stalls    = 0;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_data  = d;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk); #1;
        req_valid = 1'b0;
        return;
      end
      stalls++;
    end
    chk("req_accept_timeout", DW'(req_ready), DW'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    rand_rdy  = 1'b0;
    rdy_fixed = 1'b1;
    for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
    chk("drain_left", DW'(q.size()), '0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int st;
    int tot;
    int acc;

    #1 rst_n = 1'b0;
    #1 chk_reset_vals("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_init();

    // Write then read the same address back-to-back.
    rdy_fixed = 1'b1;
    issue(1'b1, 2'd2, 72'hAB_CDEF_0123_4567_89AB, st);
    issue(1'b0, 2'd2, '0, st);
    drain();

    // Fill all addresses, then stream reads with the consumer always ready.
    tot = 0;
    for (int i = 0; i < 4; i++) begin issue(1'b1, AW'(i), DW'(8'h10 + i), st); tot += st; end
    for (int i = 0; i < 4; i++) begin issue(1'b0, AW'(i), '0, st); tot += st; end
    chk("stream_no_stall", DW'(tot), '0);
    drain();

    // Consumer stalled: only RSP_DEPTH of 6 offered reads may be accepted.
    rdy_fixed = 1'b0;
    acc       = 0;
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = '0;
    for (int i = 0; i < 12 && acc < 6; i++) begin
      @(negedge clk);
      if (req_ready) acc++;
      @(posedge clk); #1;
      req_addr = acc[AW-1:0];
    end
    chk("bp_accepted", DW'(acc), DW'(RD));
    @(negedge clk);
    chk("bp_ready_low", DW'(req_ready), '0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rdy_fixed = 1'b1;
    @(negedge clk);
    chk("bp_ready_before_pop", DW'(req_ready), '0);
    @(negedge clk);
    chk("bp_ready_after_pop", DW'(req_ready), DW'(1));
    @(posedge clk); #1;
    drain();

    // Full FIFO, then simultaneous pop and read accept every cycle.
    rdy_fixed = 1'b0;
    for (int i = 0; i < 4; i++) issue(1'b0, AW'($urandom_range(0, 3)), '0, st);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("full_ready_low", DW'(req_ready), '0);
    @(posedge clk); #1;
    rdy_fixed = 1'b1;
    for (int i = 0; i < 8; i++) issue(1'b0, AW'($urandom_range(0, 3)), '0, st);
    drain();

    // Random mixed traffic with a randomly stalling consumer.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom() % 2), AW'($urandom_range(0, 3)), rnd72(), st);
    end
    drain();

    // Reset with one response queued and two reads in flight.
    for (int i = 0; i < 4; i++) issue(1'b1, AW'(i), rnd72() | DW'(1), st);
    rdy_fixed = 1'b0;
    for (int i = 0; i < 3; i++) issue(1'b0, AW'(i), '0, st);
    rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    rdy_fixed = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_init();
    for (int i = 0; i < 4; i++) issue(1'b0, AW'(i), '0, st);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
